// File: rtl/mem_access.sv
// rtl/mem_access.sv - memory-access pipeline stage: byte-enabled req/ack data-memory port and write-back register
// Optional bus watchdog enabled by defining MEM_ACCESS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_m,
  input  logic        reg_write_m,
  input  logic        mem_write_m,
  input  logic [1:0]  result_src_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] alu_result_m,
  input  logic [31:0] write_data_m,
  input  logic [31:0] pc_plus4_m,
  input  logic [1:0]  result_bytes_m,
  input  logic        load_unsigned_m,
  output logic [31:0] alu_result_fwd,
  output logic        stall_m,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        valid_w,
  output logic        reg_write_w,
  output logic [1:0]  result_src_w,
  output logic [4:0]  rd_w,
  output logic [31:0] alu_result_w,
  output logic [31:0] read_data_w,
  output logic [31:0] pc_plus4_w,
  output logic        misalign_w
`ifdef MEM_ACCESS_TIMEOUT_EN
  , output logic      bus_err_w
`endif
);

  typedef enum logic {IDLE, BUS} state_t;
  state_t state;

  logic        mem_op;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;
  logic [31:0] lane;
  logic [31:0] load_ext;
  logic        ack_taken;
  logic        timeout_hit;
  logic        bus_done;

  assign alu_result_fwd = alu_result_m;
  assign mem_op = valid_m & (mem_write_m | (result_src_m == 2'b01));

  always_comb begin
    misaligned = 1'b0;
    be_next    = 4'b1111;
    wdata_next = write_data_m;
    case (result_bytes_m)
      2'b00: begin
        be_next    = 4'b0001 << alu_result_m[1:0];
        wdata_next = {4{write_data_m[7:0]}};
      end
      2'b01: begin
        misaligned = alu_result_m[0];
        be_next    = 4'b0011 << alu_result_m[1:0];
        wdata_next = {2{write_data_m[15:0]}};
      end
      2'b10: misaligned = |alu_result_m[1:0];
      default: misaligned = 1'b1;
    endcase
  end

  // The upstream registers are frozen while in BUS, so the stage inputs still
  // describe the outstanding access when the ack arrives.
  assign lane = mem_rdata >> {alu_result_m[1:0], 3'b000};

  always_comb begin
    load_ext = lane;
    case (result_bytes_m)
      2'b00: load_ext = load_unsigned_m ? {24'd0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      2'b01: load_ext = load_unsigned_m ? {16'd0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
      default: load_ext = lane;
    endcase
  end

  assign ack_taken = (state == BUS) & mem_ack;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;
  assign timeout_hit = (state == BUS) & ~mem_ack & (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic unused_cfg;
  assign unused_cfg  = |TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  assign bus_done = ack_taken | timeout_hit;
  assign stall_m  = ((state == IDLE) & mem_op & ~misaligned) | ((state == BUS) & ~bus_done);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
      valid_w      <= 1'b0;
      reg_write_w  <= 1'b0;
      result_src_w <= '0;
      rd_w         <= '0;
      alu_result_w <= '0;
      read_data_w  <= '0;
      pc_plus4_w   <= '0;
      misalign_w   <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      wait_cnt     <= '0;
      bus_err_w    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_op & ~misaligned) begin
            state     <= BUS;
            mem_req   <= 1'b1;
            mem_we    <= mem_write_m;
            mem_addr  <= {alu_result_m[31:2], 2'b00};
            mem_be    <= be_next;
            mem_wdata <= wdata_next;
`ifdef MEM_ACCESS_TIMEOUT_EN
            wait_cnt  <= '0;
`endif
          end
        end
        BUS: begin
          if (bus_done) begin
            state   <= IDLE;
            mem_req <= 1'b0;
          end
`ifdef MEM_ACCESS_TIMEOUT_EN
          else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase

      if (stall_m) begin
        valid_w     <= 1'b0;
        reg_write_w <= 1'b0;
        misalign_w  <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
        bus_err_w   <= 1'b0;
`endif
      end else begin
        valid_w      <= valid_m;
        reg_write_w  <= valid_m & reg_write_m & ~mem_write_m & ~(mem_op & misaligned) & ~timeout_hit;
        result_src_w <= result_src_m;
        rd_w         <= rd_m;
        alu_result_w <= alu_result_m;
        read_data_w  <= (ack_taken & ~mem_write_m) ? load_ext : '0;
        pc_plus4_w   <= pc_plus4_m;
        misalign_w   <= mem_op & misaligned;
`ifdef MEM_ACCESS_TIMEOUT_EN
        bus_err_w    <= timeout_hit;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - randomized self-checking bench for mem_access against a size/offset arithmetic model
module tb_mem_access;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int unsigned TO = 4;
`else
  localparam int unsigned TO = 255;
`endif

  logic        clk, rst;
  logic        valid_m, reg_write_m, mem_write_m, load_unsigned_m;
  logic [1:0]  result_src_m, result_bytes_m;
  logic [4:0]  rd_m;
  logic [31:0] alu_result_m, write_data_m, pc_plus4_m;
  logic [31:0] alu_result_fwd;
  logic        stall_m, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  logic        valid_w, reg_write_w, misalign_w;
  logic [1:0]  result_src_w;
  logic [4:0]  rd_w;
  logic [31:0] alu_result_w, read_data_w, pc_plus4_w;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic        bus_err_w;
`endif

  int n_cmp = 0;
  int n_err = 0;

  mem_access #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .valid_m(valid_m), .reg_write_m(reg_write_m), .mem_write_m(mem_write_m),
    .result_src_m(result_src_m), .rd_m(rd_m), .alu_result_m(alu_result_m),
    .write_data_m(write_data_m), .pc_plus4_m(pc_plus4_m),
    .result_bytes_m(result_bytes_m), .load_unsigned_m(load_unsigned_m),
    .alu_result_fwd(alu_result_fwd), .stall_m(stall_m),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .valid_w(valid_w), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .rd_w(rd_w), .alu_result_w(alu_result_w), .read_data_w(read_data_w),
    .pc_plus4_w(pc_plus4_w), .misalign_w(misalign_w)
`ifdef MEM_ACCESS_TIMEOUT_EN
    , .bus_err_w(bus_err_w)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got hang required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h required 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: an access of 'size' bytes at byte offset 'off' within the word.
  function automatic int ref_size(input logic [1:0] nb);
    return 1 << nb;
  endfunction

  function automatic bit ref_mis(input logic [1:0] nb, input int off);
    return (nb == 2'b11) || ((off % ref_size(nb)) != 0);
  endfunction

  function automatic logic [3:0] ref_be(input int size, input int off);
    return 4'(((1 << size) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input int size);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % size) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input int off, input int size, input bit uns);
    longint val;
    longint span;
    span = longint'(1) << (8 * size);
    val  = (longint'(rd) >> (8 * off)) % span;
    if (!uns && val >= span / 2) val = val - span;
    return 32'(val);
  endfunction

  task automatic do_op(input bit v, input bit rw, input bit mw, input logic [1:0] rs,
                       input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] pc, input logic [1:0] nb, input bit uns,
                       input logic [31:0] rdata, input int dly);
    bit memop, mis;
    int off, size;
    logic [31:0] exp_rd;
    valid_m = v; reg_write_m = rw; mem_write_m = mw; result_src_m = rs; rd_m = rd;
    alu_result_m = addr; write_data_m = wd; pc_plus4_m = pc;
    result_bytes_m = nb; load_unsigned_m = uns;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    off   = int'(addr[1:0]);
    size  = ref_size(nb);
    memop = v && (mw || rs == 2'b01);
    mis   = ref_mis(nb, off);
    exp_rd = (memop && !mis && !mw) ? ref_load(rdata, off, size, uns) : 32'd0;
    @(negedge clk);
    check("fwd", alu_result_fwd, addr);
    check("stall_idle", 32'(stall_m), 32'(memop && !mis));
    check("req_idle", 32'(mem_req), 0);
    if (memop && !mis) begin
      for (int k = 0; k <= dly; k++) begin
        @(posedge clk); #1;
        mem_ack   = (k == dly);
        mem_rdata = (k == dly) ? rdata : $urandom;
        @(negedge clk);
        check("req_bus", 32'(mem_req), 1);
        check("addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("we", 32'(mem_we), 32'(mw));
        check("be", 32'(mem_be), 32'(ref_be(size, off)));
        check("wdata", mem_wdata, ref_wdata(wd, size));
        check("stall_bus", 32'(stall_m), 32'(k < dly));
        check("bubble_valid", 32'(valid_w), 0);
        check("fwd_stalled", alu_result_fwd, addr);
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("req_after", 32'(mem_req), 0);
    check("valid_w", 32'(valid_w), 32'(v));
    check("reg_write_w", 32'(reg_write_w), 32'(v && rw && !mw && !(memop && mis)));
    check("misalign_w", 32'(misalign_w), 32'(memop && mis));
    check("read_data_w", read_data_w, exp_rd);
    check("rd_w", 32'(rd_w), 32'(rd));
    check("alu_result_w", alu_result_w, addr);
    check("pc_plus4_w", pc_plus4_w, pc);
    check("result_src_w", 32'(result_src_w), 32'(rs));
`ifdef MEM_ACCESS_TIMEOUT_EN
    check("bus_err_w", 32'(bus_err_w), 0);
`endif
  endtask

  initial begin
    int reqs;
    rst = 1'b0;
    valid_m = 0; reg_write_m = 0; mem_write_m = 0; result_src_m = 0; rd_m = 0;
    alu_result_m = 32'h0000_0ABC; write_data_m = 0; pc_plus4_m = 0;
    result_bytes_m = 0; load_unsigned_m = 0; mem_ack = 0; mem_rdata = 0;
    #3;
    check("rst_fwd", alu_result_fwd, 32'h0000_0ABC);
    check("rst_req", 32'(mem_req), 0);
    check("rst_stall", 32'(stall_m), 0);
    check("rst_valid_w", 32'(valid_w), 0);
    check("rst_reg_write_w", 32'(reg_write_w), 0);
    check("rst_read_data_w", read_data_w, 0);
    check("rst_mem_be", 32'(mem_be), 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_misalign_w", 32'(misalign_w), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    do_op(1, 1, 0, 2'b01, 5'd3, 32'h100, 32'h0, 32'h44, 2'b10, 0, 32'hDEADBEEF, 0);
    check("plan_word_load", read_data_w, 32'hDEADBEEF);
    do_op(1, 1, 0, 2'b01, 5'd4, 32'h103, 32'h0, 32'h48, 2'b00, 0, 32'h8000_0000, 0);
    check("plan_sbyte", read_data_w, 32'hFFFF_FF80);
    do_op(1, 1, 0, 2'b01, 5'd4, 32'h103, 32'h0, 32'h4C, 2'b00, 1, 32'h8000_0000, 1);
    check("plan_ubyte", read_data_w, 32'h0000_0080);
    do_op(1, 0, 1, 2'b00, 5'd0, 32'h202, 32'h1234ABCD, 32'h50, 2'b01, 0, 32'h0, 0);
    do_op(1, 1, 0, 2'b01, 5'd7, 32'h300, 32'h0, 32'h54, 2'b10, 0, 32'hCAFEF00D, 3);
    do_op(1, 1, 0, 2'b01, 5'd8, 32'h101, 32'h0, 32'h58, 2'b10, 0, 32'h0, 0);
    do_op(1, 1, 0, 2'b00, 5'd9, 32'h1234, 32'h0, 32'h5C, 2'b10, 0, 32'h0, 0);
    do_op(1, 1, 0, 2'b01, 5'd9, 32'h400, 32'h0, 32'h60, 2'b11, 0, 32'h0, 0);

    for (int i = 0; i < 60; i++) begin
      do_op(($urandom % 8) != 0, 1'($urandom), ($urandom % 3) == 0, 2'($urandom),
            5'($urandom), $urandom, $urandom, $urandom, 2'($urandom), 1'($urandom),
            $urandom, int'($urandom_range(0, 3)));
    end

    // Reset while a transaction is outstanding.
    valid_m = 1; reg_write_m = 1; mem_write_m = 0; result_src_m = 2'b01;
    alu_result_m = 32'h500; result_bytes_m = 2'b10; mem_ack = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("pre_rst_req", 32'(mem_req), 1);
    #1 rst = 1'b0;
    #1;
    check("rst_bus_req", 32'(mem_req), 0);
    check("rst_bus_valid_w", 32'(valid_w), 0);
    valid_m = 0;
    #1;
    check("rst_bus_idle_stall", 32'(stall_m), 0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("rst_bus_no_req", 32'(mem_req), 0);

`ifdef MEM_ACCESS_TIMEOUT_EN
    valid_m = 1; reg_write_m = 1; mem_write_m = 0; result_src_m = 2'b01; rd_m = 5'd12;
    alu_result_m = 32'h600; result_bytes_m = 2'b10; mem_ack = 0;
    reqs = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_req) reqs++;
      if (c > 0 && !mem_req) break;
    end
    check("timeout_req_cycles", 32'(reqs), 32'(TO));
    check("bus_err_w", 32'(bus_err_w), 1);
    check("timeout_reg_write_w", 32'(reg_write_w), 0);
    check("timeout_valid_w", 32'(valid_w), 1);
    valid_m = 0;
    @(posedge clk); #1;
`else
    reqs = 0;
    check("no_timeout_req", 32'(mem_req) + 32'(reqs), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
